// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out stage for the 0110 sequence detectors.
//   A word taken over valid/ready goes into a one-word holding register. It is then
//   shifted out one bit per clock on bit_o. When the last bit leaves and another word
//   is already held, that word is reloaded on the same edge, so there is no idle gap.
// Ports:
//   clk          in   single clock, all state on posedge
//   rstn         in   asynchronous active-low reset
//   data_i       in   parallel word, sampled only on handshake
//   valid_i      in   upstream word valid
//   ready_o      out  holding register empty
//   clr_i        in   synchronous abort of held and shifting words
//   bit_o        out  serial data (IDLE_BIT when not shifting)
//   bit_valid_o  out  bit_o carries a data bit this cycle
//   busy_o       out  a word is held or shifting
//
// state | meaning
// IDLE  | nothing shifting; bit_o = IDLE_BIT
// SHIFT | word in shift register, bit cnt on bit_o
module piso_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             clr_i,
  output logic             bit_o,
  output logic             bit_valid_o,
  output logic             busy_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic [WIDTH-1:0] shift_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
    end
  end

  // ready_o depends only on registered state, so accept has no path through ready.
  assign ready_o = !hold_valid_q;
  assign accept  = valid_i & ready_o & !clr_i;

  assign shift_next = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shift_q[WIDTH-1:1]};

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;

    if (clr_i) begin
      state_d      = IDLE;
      hold_d       = '0;
      hold_valid_d = 1'b0;
      shift_d      = '0;
      cnt_d        = '0;
    end else begin
      // accept only happens with hold empty, so it never collides with the
      // hold->shift transfers below (those require hold_valid_q).
      if (accept) begin
        hold_d       = data_i;
        hold_valid_d = 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (hold_valid_q) begin
            state_d      = SHIFT;
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            cnt_d        = '0;
          end
        end
        SHIFT: begin
          if (cnt_q != CNT_LAST) begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = shift_next;
          end else if (hold_valid_q) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            cnt_d        = '0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bit_valid_o = (state_q == SHIFT);
  assign busy_o      = (state_q == SHIFT) | hold_valid_q;
  assign bit_o       = (state_q == SHIFT) ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0])
                                          : IDLE_BIT;

endmodule
